// File: rtl/usb_packet_rx_pkg.sv
// Shared constants for the USB receive packet layer: states, PID classes, error codes, CRC setup.
package usb_packet_rx_pkg;

    localparam int unsigned MaxBytesDefault = 67;

    typedef enum logic [1:0] {
        StIdle,
        StPid,
        StData,
        StDiscard
    } rx_state_e;

    typedef enum logic [1:0] {
        PktToken     = 2'd0,
        PktData      = 2'd1,
        PktHandshake = 2'd2,
        PktSpecial   = 2'd3
    } pkt_type_e;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSof   = 4'b0101;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidData2 = 4'b0111;
    localparam logic [3:0] PidMdata = 4'b1111;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidNyet  = 4'b0110;

    localparam logic [2:0] ErrNone   = 3'd0;
    localparam logic [2:0] ErrPid    = 3'd1;
    localparam logic [2:0] ErrBit    = 3'd2;
    localparam logic [2:0] ErrAlign  = 3'd3;
    localparam logic [2:0] ErrCrc    = 3'd4;
    localparam logic [2:0] ErrLength = 3'd5;

    localparam logic [4:0]  Crc5Poly      = 5'h05;
    localparam logic [4:0]  Crc5Preset    = 5'h1F;
    localparam logic [4:0]  Crc5Residual  = 5'b01100;
    localparam logic [15:0] Crc16Poly     = 16'h8005;
    localparam logic [15:0] Crc16Preset   = 16'hFFFF;
    localparam logic [15:0] Crc16Residual = 16'h800D;

    function automatic pkt_type_e pid_class(input logic [3:0] pid);
        case (pid)
            PidOut, PidIn, PidSof, PidSetup:       pid_class = PktToken;
            PidData0, PidData1, PidData2, PidMdata: pid_class = PktData;
            PidAck, PidNak, PidStall, PidNyet:     pid_class = PktHandshake;
            default:                               pid_class = PktSpecial;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC engine with preset, shift enable and residual match.
// Compiled only when RX_CRC_CHECK_EN is defined.
`ifdef RX_CRC_CHECK_EN
module usb_crc_serial #(
    parameter int unsigned           Width    = 5,
    parameter logic [Width-1:0]      Poly     = '0,
    parameter logic [Width-1:0]      Preset   = '1,
    parameter logic [Width-1:0]      Residual = '0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_preset,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match
);

    logic [Width-1:0] r_crc;
    logic             w_fb;

    assign w_fb = i_bit ^ r_crc[Width-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= '0;
        end else if (i_preset) begin
            r_crc <= Preset;
        end else if (i_shift) begin
            r_crc <= {r_crc[Width-2:0], 1'b0} ^ (Poly & {Width{w_fb}});
        end
    end

    assign o_match = (r_crc == Residual);

endmodule
`endif

// File: rtl/usb_packet_rx.sv
// Receive packet layer: deserialises unstuffed bits, validates PID, checks length and
// (with RX_CRC_CHECK_EN defined) CRC5/CRC16, and reports a per-packet verdict.
module usb_packet_rx
    import usb_packet_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MaxBytesDefault
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_rx_start,
    input  logic                               i_rx_status,
    input  logic                               i_rx_bit,
    input  logic                               i_rx_finish,
    input  logic                               i_rx_error,
    output logic                               o_pkt_start,
    output logic [3:0]                         o_pid,
    output logic [1:0]                         o_pkt_type,
    output logic                               o_byte_valid,
    output logic [7:0]                         o_byte_data,
    output logic [$clog2(MAX_BYTES+1)-1:0]     o_byte_cnt,
    output logic                               o_pkt_end,
    output logic                               o_pkt_ok,
    output logic [2:0]                         o_err_code
);

    localparam int unsigned CntW = $clog2(MAX_BYTES + 1);

    rx_state_e       r_state, w_state_next;
    logic [7:0]      r_shift, w_shift_next;
    logic [2:0]      r_bit_cnt, w_bit_cnt_next;
    logic [CntW-1:0] r_byte_cnt, w_byte_cnt_next;
    logic [2:0]      r_pend_err, w_pend_err_next;
    logic [3:0]      r_pid, w_pid_next;
    pkt_type_e       r_pkt_type, w_pkt_type_next;
    logic            r_pkt_start, w_pkt_start_next;
    logic            r_byte_valid, w_byte_valid_next;
    logic [7:0]      r_byte_data, w_byte_data_next;
    logic            r_pkt_end, w_pkt_end_next;
    logic            r_pkt_ok, w_pkt_ok_next;
    logic [2:0]      r_err_code, w_err_code_next;

    logic [7:0]      w_byte;
    logic            w_last_bit;
    logic            w_len_ok;

    assign w_byte     = {i_rx_bit, r_shift[7:1]};
    assign w_last_bit = (r_bit_cnt == 3'd7);

`ifdef RX_CRC_CHECK_EN
    logic w_crc_preset, w_crc_shift, w_crc5_match, w_crc16_match, w_crc_ok;

    // Mirrors the event priority: preset only on an accepted rx_start, shift on DATA bits.
    assign w_crc_preset = i_rx_start & ~i_rx_error & ~i_rx_finish;
    assign w_crc_shift  = i_rx_status & ~i_rx_start & ~i_rx_error & ~i_rx_finish &
                          (r_state == StData);

    usb_crc_serial #(
        .Width   (5),
        .Poly    (Crc5Poly),
        .Preset  (Crc5Preset),
        .Residual(Crc5Residual)
    ) u_crc5 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_preset(w_crc_preset),
        .i_shift (w_crc_shift),
        .i_bit   (i_rx_bit),
        .o_match (w_crc5_match)
    );

    usb_crc_serial #(
        .Width   (16),
        .Poly    (Crc16Poly),
        .Preset  (Crc16Preset),
        .Residual(Crc16Residual)
    ) u_crc16 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_preset(w_crc_preset),
        .i_shift (w_crc_shift),
        .i_bit   (i_rx_bit),
        .o_match (w_crc16_match)
    );

    assign w_crc_ok = (r_pkt_type == PktToken) ? w_crc5_match :
                      (r_pkt_type == PktData)  ? w_crc16_match : 1'b1;
`endif

    always_comb begin
        case (r_pkt_type)
            PktToken:     w_len_ok = (r_byte_cnt == CntW'(2));
            PktData:      w_len_ok = (r_byte_cnt >= CntW'(2));
            PktHandshake: w_len_ok = (r_byte_cnt == CntW'(0));
            default:      w_len_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_cnt_next    = r_bit_cnt;
        w_byte_cnt_next   = r_byte_cnt;
        w_pend_err_next   = r_pend_err;
        w_pid_next        = r_pid;
        w_pkt_type_next   = r_pkt_type;
        w_pkt_start_next  = 1'b0;
        w_byte_valid_next = 1'b0;
        w_byte_data_next  = r_byte_data;
        w_pkt_end_next    = 1'b0;
        w_pkt_ok_next     = r_pkt_ok;
        w_err_code_next   = r_err_code;

        if (i_rx_error) begin
            if (r_state != StIdle) begin
                w_pkt_end_next  = 1'b1;
                w_pkt_ok_next   = 1'b0;
                w_err_code_next = ErrBit;
                w_state_next    = StIdle;
            end
        end else if (i_rx_finish) begin
            if (r_state != StIdle) begin
                w_pkt_end_next = 1'b1;
                w_pkt_ok_next  = 1'b0;
                w_state_next   = StIdle;
            end
            case (r_state)
                StPid:     w_err_code_next = ErrAlign;
                StDiscard: w_err_code_next = r_pend_err;
                StData: begin
                    if (r_bit_cnt != 3'd0) begin
                        w_err_code_next = ErrAlign;
                    end else if (!w_len_ok) begin
                        w_err_code_next = ErrLength;
`ifdef RX_CRC_CHECK_EN
                    end else if (!w_crc_ok) begin
                        w_err_code_next = ErrCrc;
`endif
                    end else begin
                        w_err_code_next = ErrNone;
                        w_pkt_ok_next   = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (i_rx_start) begin
            // A start inside a packet aborts it and restarts in the same cycle.
            if (r_state != StIdle) begin
                w_pkt_end_next  = 1'b1;
                w_pkt_ok_next   = 1'b0;
                w_err_code_next = ErrBit;
            end
            w_state_next    = StPid;
            w_shift_next    = '0;
            w_bit_cnt_next  = '0;
            w_byte_cnt_next = '0;
            w_pend_err_next = ErrNone;
        end else if (i_rx_status) begin
            case (r_state)
                StPid: begin
                    w_shift_next   = w_byte;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (w_last_bit) begin
                        if (w_byte[7:4] == ~w_byte[3:0]) begin
                            w_pid_next       = w_byte[3:0];
                            w_pkt_type_next  = pid_class(w_byte[3:0]);
                            w_pkt_start_next = 1'b1;
                            w_state_next     = StData;
                        end else begin
                            w_pend_err_next = ErrPid;
                            w_state_next    = StDiscard;
                        end
                    end
                end
                StData: begin
                    w_shift_next   = w_byte;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (w_last_bit) begin
                        if (r_byte_cnt == CntW'(MAX_BYTES)) begin
                            w_pend_err_next = ErrLength;
                            w_state_next    = StDiscard;
                        end else begin
                            w_byte_valid_next = 1'b1;
                            w_byte_data_next  = w_byte;
                            w_byte_cnt_next   = r_byte_cnt + CntW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_pend_err   <= ErrNone;
            r_pid        <= '0;
            r_pkt_type   <= PktToken;
            r_pkt_start  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_pkt_end    <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_err_code   <= ErrNone;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_pend_err   <= w_pend_err_next;
            r_pid        <= w_pid_next;
            r_pkt_type   <= w_pkt_type_next;
            r_pkt_start  <= w_pkt_start_next;
            r_byte_valid <= w_byte_valid_next;
            r_byte_data  <= w_byte_data_next;
            r_pkt_end    <= w_pkt_end_next;
            r_pkt_ok     <= w_pkt_ok_next;
            r_err_code   <= w_err_code_next;
        end
    end

    assign o_pkt_start  = r_pkt_start;
    assign o_pid        = r_pid;
    assign o_pkt_type   = r_pkt_type;
    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_byte_cnt   = r_byte_cnt;
    assign o_pkt_end    = r_pkt_end;
    assign o_pkt_ok     = r_pkt_ok;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_usb_packet_rx.sv
// Scoreboard bench for usb_packet_rx: directed and random packets against a packet-level model.
module tb_usb_packet_rx;

    localparam int unsigned MaxBytes = 67;
    localparam int unsigned CntW     = $clog2(MaxBytes + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx_start = 1'b0, rx_status = 1'b0, rx_bit = 1'b0;
    logic            rx_finish = 1'b0, rx_error = 1'b0;
    logic            o_pkt_start, o_byte_valid, o_pkt_end, o_pkt_ok;
    logic [3:0]      o_pid;
    logic [1:0]      o_pkt_type;
    logic [7:0]      o_byte_data;
    logic [CntW-1:0] o_byte_cnt;
    logic [2:0]      o_err_code;

    usb_packet_rx #(.MAX_BYTES(MaxBytes)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_start  (rx_start),
        .i_rx_status (rx_status),
        .i_rx_bit    (rx_bit),
        .i_rx_finish (rx_finish),
        .i_rx_error  (rx_error),
        .o_pkt_start (o_pkt_start),
        .o_pid       (o_pid),
        .o_pkt_type  (o_pkt_type),
        .o_byte_valid(o_byte_valid),
        .o_byte_data (o_byte_data),
        .o_byte_cnt  (o_byte_cnt),
        .o_pkt_end   (o_pkt_end),
        .o_pkt_ok    (o_pkt_ok),
        .o_err_code  (o_err_code)
    );

    always #8 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q_start[$];      // (pid << 2) | class
    int q_byte[$];       // (count << 8) | data
    int q_end[$];        // (count << 4) | (ok << 3) | code
    logic [7:0] pkt[$];  // post-PID bytes of the packet being built
    bit open_pkt = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_pkt_start) begin
                if (q_start.size() == 0) unexpected("pkt_start", int'(o_pid));
                else check("pkt_start pid/type", int'({o_pid, o_pkt_type}), q_start.pop_front());
            end
            if (o_byte_valid) begin
                if (q_byte.size() == 0) unexpected("byte_valid", int'(o_byte_data));
                else check("byte cnt/data", int'({o_byte_cnt, o_byte_data}), q_byte.pop_front());
            end
            if (o_pkt_end) begin
                if (q_end.size() == 0) unexpected("pkt_end", int'(o_err_code));
                else check("pkt_end cnt/ok/code", int'({o_byte_cnt, o_pkt_ok, o_err_code}),
                           q_end.pop_front());
            end
        end
    end

    task automatic drive(input logic s, input logic st, input logic b, input logic f,
                         input logic e);
        @(posedge clk); #1;
        rx_start = s; rx_status = st; rx_bit = b; rx_finish = f; rx_error = e;
        @(posedge clk); #1;
        rx_start = 1'b0; rx_status = 1'b0; rx_bit = 1'b0; rx_finish = 1'b0; rx_error = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    function automatic bit pid_ok(input logic [7:0] p);
        return p[7:4] == ~p[3:0];
    endfunction

    function automatic int class_of(input logic [3:0] p);
        if (p inside {4'b0001, 4'b1001, 4'b0101, 4'b1101}) return 0;
        if (p inside {4'b0011, 4'b1011, 4'b0111, 4'b1111}) return 1;
        if (p inside {4'b0010, 4'b1010, 4'b1110, 4'b0110}) return 2;
        return 3;
    endfunction

    function automatic bit len_ok(input int cls, input int n);
        case (cls)
            0:       return n == 2;
            1:       return n >= 2;
            2:       return n == 0;
            default: return 1'b1;
        endcase
    endfunction

    // CRC remainder register over all bits of pkt, LSB of each byte first.
    function automatic int crc_of_pkt(input int width, input int poly, input int preset);
        int r;
        int mask;
        r = preset;
        mask = (1 << width) - 1;
        foreach (pkt[i]) begin
            for (int j = 0; j < 8; j++) begin
                int fb;
                fb = int'(pkt[i][j]) ^ ((r >> (width - 1)) & 1);
                r = ((r << 1) & mask) ^ (fb != 0 ? poly : 0);
            end
        end
        return r;
    endfunction

    // end_kind: 0 rx_finish, 1 rx_error, 2 leave open (next start aborts it)
    task automatic run_packet(input logic [7:0] pid_byte, input int pid_bits, input int extra,
                              input logic [7:0] extra_val, input int end_kind);
        int n, cls, delivered, code, ok;
        bit valid;
        n = pkt.size();
        if (open_pkt) q_end.push_back(2);
        valid = (pid_bits == 8) && pid_ok(pid_byte);
        cls = class_of(pid_byte[3:0]);
        delivered = !valid ? 0 : (n > MaxBytes ? MaxBytes : n);
        if (valid) q_start.push_back((int'(pid_byte[3:0]) << 2) | cls);
        for (int i = 0; i < delivered; i++) q_byte.push_back(((i + 1) << 8) | int'(pkt[i]));
        ok = 0;
        if (pid_bits < 8) code = 3;
        else if (!pid_ok(pid_byte)) code = 1;
        else if (n > MaxBytes) code = 5;
        else if (extra != 0) code = 3;
        else if (!len_ok(cls, n)) code = 5;
`ifdef RX_CRC_CHECK_EN
        else if ((cls == 0 && crc_of_pkt(5, 'h05, 'h1F) != 'h0C) ||
                 (cls == 1 && crc_of_pkt(16, 'h8005, 'hFFFF) != 'h800D)) code = 4;
`endif
        else begin
            code = 0;
            ok = 1;
        end

        drive(1, 0, 0, 0, 0);
        open_pkt = 1'b1;
        for (int i = 0; i < pid_bits; i++) drive(0, 1, pid_byte[i], 0, 0);
        foreach (pkt[i]) for (int j = 0; j < 8; j++) drive(0, 1, pkt[i][j], 0, 0);
        for (int j = 0; j < extra; j++) drive(0, 1, extra_val[j], 0, 0);

        if (end_kind == 0) begin
            q_end.push_back((delivered << 4) | (ok << 3) | code);
            drive(0, 0, 0, 1, 0);
            open_pkt = 1'b0;
        end else if (end_kind == 1) begin
            q_end.push_back((delivered << 4) | 2);
            drive(0, 0, 0, 0, 1);
            open_pkt = 1'b0;
        end
    endtask

    task automatic make_token();
        logic [7:0] tmp;
        pkt.delete();
        pkt.push_back(8'($urandom));
        pkt.push_back(8'($urandom));
        for (int c = 0; c < 32; c++) begin
            tmp = {c[4:0], pkt[1][2:0]};
            pkt[1] = tmp;
            if (crc_of_pkt(5, 'h05, 'h1F) == 'h0C) break;
        end
    endtask

    task automatic make_data(input int n);
        int crc;
        logic [15:0] inv;
        logic [7:0] b0, b1;
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
        crc = crc_of_pkt(16, 'h8005, 'hFFFF);
        inv = ~crc[15:0];
        for (int k = 0; k < 8; k++) begin
            b0[k] = inv[15 - k];
            b1[k] = inv[7 - k];
        end
        pkt.push_back(b0);
        pkt.push_back(b1);
    endtask

    initial begin
        logic [7:0] pidb;
        logic [3:0] p4;
        int sel, pb, extra, kind, cls;

        repeat (3) @(posedge clk);
        #1;
        check("reset pkt_start", o_pkt_start, 0);
        check("reset pid", o_pid, 0);
        check("reset pkt_type", o_pkt_type, 0);
        check("reset byte_valid", o_byte_valid, 0);
        check("reset byte_data", o_byte_data, 0);
        check("reset byte_cnt", int'(o_byte_cnt), 0);
        check("reset pkt_end", o_pkt_end, 0);
        check("reset pkt_ok", o_pkt_ok, 0);
        check("reset err_code", o_err_code, 0);
        rst_n = 1'b1;

        // Events while idle are ignored.
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);

        pkt.delete();                                     run_packet(8'hD2, 8, 0, 0, 0);
        pkt = '{8'h00, 8'h10};                            run_packet(8'h69, 8, 0, 0, 0);
        pkt = '{8'h00, 8'h11};                            run_packet(8'h69, 8, 0, 0, 0);
        pkt = '{8'h00, 8'h00};                            run_packet(8'hC3, 8, 0, 0, 0);
        pkt.delete();                                     run_packet(8'hC3, 8, 0, 0, 0);
        pkt = '{8'h12, 8'h34};                            run_packet(8'hC2, 8, 0, 0, 0);
        pkt = '{8'h00};                                   run_packet(8'h2D, 8, 3, 8'h05, 0);
        pkt = '{8'hA5};                                   run_packet(8'h4B, 8, 3, 8'h02, 1);
        pkt.delete();                                     run_packet(8'hD2, 8, 0, 0, 0);
        pkt.delete();                                     run_packet(8'hD2, 5, 0, 0, 0);
        pkt = '{8'h00, 8'h10};                            run_packet(8'h69, 8, 0, 0, 2);
        pkt.delete();                                     run_packet(8'h5A, 8, 0, 0, 0);
        pkt.delete();
        for (int i = 0; i < 70; i++) pkt.push_back(8'($urandom));
        run_packet(8'hC3, 8, 0, 0, 0);

        // Finish beats a simultaneous bit: ACK stays at zero bytes.
        pkt.delete();
        run_packet(8'hD2, 8, 0, 0, 2);
        q_end.push_back(8);
        drive(0, 1, 1, 1, 0);
        open_pkt = 1'b0;
        // Error beats finish.
        pkt = '{8'h00, 8'h10};
        run_packet(8'h69, 8, 0, 0, 2);
        q_end.push_back((2 << 4) | 2);
        drive(0, 0, 0, 1, 1);
        open_pkt = 1'b0;
        // Finish beats start: packet closes normally and no new packet opens.
        pkt.delete();
        run_packet(8'hD2, 8, 0, 0, 2);
        q_end.push_back(8);
        drive(1, 0, 0, 1, 0);
        open_pkt = 1'b0;
        drive(0, 1, 1, 0, 0);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            p4 = 4'($urandom);
            pidb = (sel == 0) ? 8'($urandom) : {~p4, p4};
            cls = class_of(pidb[3:0]);
            pb = 8;
            pkt.delete();
            if (sel == 9) begin
                pb = $urandom_range(1, 7);
            end else if (cls == 0 && sel < 6) begin
                make_token();
            end else if (cls == 1 && sel < 6) begin
                make_data($urandom_range(0, 8));
            end else if (cls != 2 || sel > 6) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) pkt.push_back(8'($urandom));
            end
            extra = (pb == 8 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            kind = $urandom_range(0, 9);
            kind = (kind < 7) ? 0 : (kind < 9 ? 1 : 2);
            run_packet(pidb, pb, extra, 8'($urandom), kind);
        end
        if (open_pkt) begin
            q_end.push_back(2);
            drive(0, 0, 0, 0, 1);
            open_pkt = 1'b0;
        end

        // Async reset in the middle of a DATA0 packet.
        pkt = '{8'hA5};
        run_packet(8'hC3, 8, 3, 8'h07, 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid reset pkt_start", o_pkt_start, 0);
        check("mid reset pid", o_pid, 0);
        check("mid reset pkt_type", o_pkt_type, 0);
        check("mid reset byte_valid", o_byte_valid, 0);
        check("mid reset byte_data", o_byte_data, 0);
        check("mid reset byte_cnt", int'(o_byte_cnt), 0);
        check("mid reset pkt_end", o_pkt_end, 0);
        check("mid reset pkt_ok", o_pkt_ok, 0);
        check("mid reset err_code", o_err_code, 0);
        open_pkt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pkt.delete();
        run_packet(8'hD2, 8, 0, 0, 0);

        repeat (20) @(posedge clk);
        check("leftover pkt_start", q_start.size(), 0);
        check("leftover byte_valid", q_byte.size(), 0);
        check("leftover pkt_end", q_end.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
